// File: rtl/virtual_camera_pan_if.sv
// Request/offset bundle between a button front end and the camera pan block.
// W here must match the W of the virtual_camera_pan instance it connects to.
interface virtual_camera_pan_if #(
  parameter int unsigned W = 11
);
  logic         left;
  logic         right;
  logic         up;
  logic         down;
  logic         fast;
  logic         recenter;
  logic [W-1:0] x_offset;
  logic [W-1:0] y_offset;
  logic [3:0]   limit;
  logic         moved;

  modport master (
    output left, right, up, down, fast, recenter,
    input  x_offset, y_offset, limit, moved
  );

  modport slave (
    input  left, right, up, down, fast, recenter,
    output x_offset, y_offset, limit, moved
  );
endinterface

// File: rtl/virtual_camera_pan.sv
// Two-axis camera pan: per-axis step / hold-delay / auto-repeat FSMs driving
// saturating offset registers, with recenter, bound flags and a moved strobe.
module virtual_camera_pan #(
  parameter int unsigned W             = 11,
  parameter int unsigned X_INIT        = 300,
  parameter int unsigned Y_INIT        = 300,
  parameter int unsigned X_MIN         = 0,
  parameter int unsigned X_MAX         = 1023,
  parameter int unsigned Y_MIN         = 0,
  parameter int unsigned Y_MAX         = 767,
  parameter int unsigned STEP          = 1,
  parameter int unsigned FAST_STEP     = 8,
  parameter int unsigned HOLD_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 2500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  virtual_camera_pan_if.slave   cam_if
);

  localparam int unsigned CMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  // Index 0 is the x axis, index 1 the y axis.
  localparam logic [W-1:0] AX_INIT [2] = '{W'(X_INIT), W'(Y_INIT)};
  localparam logic [W-1:0] AX_MIN  [2] = '{W'(X_MIN),  W'(Y_MIN)};
  localparam logic [W-1:0] AX_MAX  [2] = '{W'(X_MAX),  W'(Y_MAX)};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } axis_state_e;

  axis_state_e   state_q [2];
  axis_state_e   state_d [2];
  logic [CW-1:0] cnt_q   [2];
  logic [CW-1:0] cnt_d   [2];
  logic [W-1:0]  off_q   [2];
  logic [W-1:0]  off_d   [2];
  logic [1:0]    dir_q;
  logic [1:0]    dir_d;
  logic          moved_q;
  logic          moved_d;

  logic [1:0]    req_neg;
  logic [1:0]    req_pos;
  logic [1:0]    step_en;
  logic [W-1:0]  step_sz;

  assign req_neg = {cam_if.up,   cam_if.left};
  assign req_pos = {cam_if.down, cam_if.right};
  assign step_sz = cam_if.fast ? W'(FAST_STEP) : W'(STEP);

  // One extra bit keeps the borrow/carry so the result clamps instead of wrapping.
  function automatic logic [W-1:0] step_val(
    input logic [W-1:0] off,
    input logic [W-1:0] sz,
    input logic         pos,
    input logic [W-1:0] lo,
    input logic [W-1:0] hi
  );
    logic [W:0]   t;
    logic [W-1:0] r;
    if (pos) begin
      t = {1'b0, off} + {1'b0, sz};
      r = (t > {1'b0, hi}) ? hi : t[W-1:0];
    end else begin
      t = {1'b0, off} - {1'b0, sz};
      r = (t[W] || (t[W-1:0] < lo)) ? lo : t[W-1:0];
    end
    step_val = r;
  endfunction

  always_comb begin
    for (int unsigned a = 0; a < 2; a++) begin
      state_d[a] = state_q[a];
      cnt_d[a]   = cnt_q[a];
      dir_d[a]   = dir_q[a];
      off_d[a]   = off_q[a];
      step_en[a] = 1'b0;

      if (req_neg[a] == req_pos[a]) begin
        state_d[a] = ST_IDLE;
        cnt_d[a]   = '0;
      end else if ((state_q[a] == ST_IDLE) || (req_pos[a] != dir_q[a])) begin
        step_en[a] = 1'b1;
        dir_d[a]   = req_pos[a];
        cnt_d[a]   = '0;
        state_d[a] = ST_DELAY;
      end else if (state_q[a] == ST_DELAY) begin
        if (cnt_q[a] == HOLD_LAST) begin
          step_en[a] = 1'b1;
          cnt_d[a]   = '0;
          state_d[a] = ST_REPEAT;
        end else begin
          cnt_d[a] = cnt_q[a] + CW'(1);
        end
      end else begin
        if (cnt_q[a] == REPEAT_LAST) begin
          step_en[a] = 1'b1;
          cnt_d[a]   = '0;
        end else begin
          cnt_d[a] = cnt_q[a] + CW'(1);
        end
      end

      if (step_en[a]) begin
        off_d[a] = step_val(off_q[a], step_sz, dir_d[a], AX_MIN[a], AX_MAX[a]);
      end

      if (cam_if.recenter) begin
        off_d[a]   = AX_INIT[a];
        state_d[a] = ST_IDLE;
        cnt_d[a]   = '0;
      end
    end

    moved_d = (off_d[0] != off_q[0]) || (off_d[1] != off_q[1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned a = 0; a < 2; a++) begin
        state_q[a] <= ST_IDLE;
        cnt_q[a]   <= '0;
        off_q[a]   <= AX_INIT[a];
      end
      dir_q   <= '0;
      moved_q <= 1'b0;
    end else begin
      for (int unsigned a = 0; a < 2; a++) begin
        state_q[a] <= state_d[a];
        cnt_q[a]   <= cnt_d[a];
        off_q[a]   <= off_d[a];
      end
      dir_q   <= dir_d;
      moved_q <= moved_d;
    end
  end

  assign cam_if.x_offset = off_q[0];
  assign cam_if.y_offset = off_q[1];
  assign cam_if.moved    = moved_q;
  assign cam_if.limit    = {off_q[1] == AX_MAX[1], off_q[1] == AX_MIN[1],
                            off_q[0] == AX_MAX[0], off_q[0] == AX_MIN[0]};

endmodule
